// File: rtl/ldst_unit_pkg.sv
// Shared types for the load/store unit: widths, FSM states,
// and the request bundle latched at acceptance.
package ldst_unit_pkg;

  localparam int FULLW = 32;
  localparam int REGAW = 4;
  localparam int LSSW  = 3;

  typedef enum logic [LSSW-1:0] {
    LS_IDLE    = 3'd0,
    LS_ACCESS  = 3'd1,
    LS_WAIT    = 3'd2,
    LS_WRITE   = 3'd3,
    LS_WB_DATA = 3'd4,
    LS_WB_BASE = 3'd5
  } ls_state_t;

  typedef struct packed {
    logic             load;
    logic             byte_acc;
    logic             need_bwb;
    logic [FULLW-1:0] ea;
    logic [FULLW-1:0] oa;
    logic [FULLW-1:0] sd;
    logic [REGAW-1:0] rd;
    logic [REGAW-1:0] rn;
  } ls_req_t;

endpackage

// File: rtl/ldst_unit_bytelane32.sv
// Big-endian byte lane helper: load extract/rotate and
// store-byte merge, selected by the low address bits.
module bytelane32
  import ldst_unit_pkg::*;
(
  input  logic [FULLW-1:0] q,
  input  logic [7:0]       sd,
  input  logic [1:0]       lane,
  input  logic             byte_acc,
  output logic [FULLW-1:0] ld,
  output logic [FULLW-1:0] merged
);

  always_comb begin
    ld     = q;
    merged = q;
    unique case (lane)
      2'd0: begin
        ld = byte_acc ? {24'b0, q[31:24]} : q;
        merged[31:24] = sd;
      end
      2'd1: begin
        ld = byte_acc ? {24'b0, q[23:16]}
                      : {q[23:0], q[31:24]};
        merged[23:16] = sd;
      end
      2'd2: begin
        ld = byte_acc ? {24'b0, q[15:8]}
                      : {q[15:0], q[31:16]};
        merged[15:8] = sd;
      end
      2'd3: begin
        ld = byte_acc ? {24'b0, q[7:0]}
                      : {q[7:0], q[31:8]};
        merged[7:0] = sd;
      end
    endcase
  end

endmodule

// File: rtl/ldst_unit.sv
// Multi-cycle LDR/STR sequencer between the decoder/register
// file and a big-endian synchronous-read data RAM.
module ldst_unit
  import ldst_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic             req_byte,
  input  logic             req_pre,
  input  logic             req_up,
  input  logic             req_wb,
  input  logic [FULLW-1:0] req_base,
  input  logic [FULLW-1:0] req_offset,
  input  logic [FULLW-1:0] req_sd,
  input  logic [REGAW-1:0] req_rd,
  input  logic [REGAW-1:0] req_rn,
  output logic [FULLW-1:0] mem_ad,
  output logic [FULLW-1:0] mem_d,
  output logic             mem_we,
  input  logic [FULLW-1:0] mem_q,
  output logic             wb_valid,
  output logic [REGAW-1:0] wb_wa,
  output logic [FULLW-1:0] wb_wd,
  output logic             done
);

  ls_state_t        state;
  ls_state_t        state_nx;
  ls_req_t          r;
  logic [FULLW-1:0] data;
  logic [FULLW-1:0] ld_val;
  logic [FULLW-1:0] mrg_val;
  logic [FULLW-1:0] oa_in;
  logic             accept;
  logic             word_st;
  logic             ld_bwb;

  assign accept  = (state == LS_IDLE) && req_valid;
  assign oa_in   = req_up ? req_base + req_offset
                          : req_base - req_offset;
  assign word_st = !r.load && !r.byte_acc;
  // a load into the base register wins over base writeback
  assign ld_bwb  = r.need_bwb && (r.rn != r.rd);

  bytelane32 u_lane (
    .q        (mem_q),
    .sd       (r.sd[7:0]),
    .lane     (r.ea[1:0]),
    .byte_acc (r.byte_acc),
    .ld       (ld_val),
    .merged   (mrg_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LS_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r    <= '0;
      data <= '0;
    end else begin
      if (accept) begin
        r.load     <= req_load;
        r.byte_acc <= req_byte;
        r.need_bwb <= !req_pre || req_wb;
        r.ea       <= req_pre ? oa_in : req_base;
        r.oa       <= oa_in;
        r.sd       <= req_sd;
        r.rd       <= req_rd;
        r.rn       <= req_rn;
      end
      if (state == LS_WAIT)
        data <= r.load ? ld_val : mrg_val;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LS_IDLE:
        if (req_valid) state_nx = LS_ACCESS;
      LS_ACCESS:
        if (!word_st)        state_nx = LS_WAIT;
        else if (r.need_bwb) state_nx = LS_WB_BASE;
        else                 state_nx = LS_IDLE;
      LS_WAIT:
        state_nx = r.load ? LS_WB_DATA : LS_WRITE;
      LS_WRITE:
        state_nx = r.need_bwb ? LS_WB_BASE : LS_IDLE;
      LS_WB_DATA:
        state_nx = ld_bwb ? LS_WB_BASE : LS_IDLE;
      LS_WB_BASE:
        state_nx = LS_IDLE;
      default:
        state_nx = LS_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_ad    = {r.ea[FULLW-1:2], 2'b00};
    mem_d     = '0;
    mem_we    = 1'b0;
    wb_valid  = 1'b0;
    wb_wa     = '0;
    wb_wd     = '0;
    done      = 1'b0;
    unique case (state)
      LS_IDLE: begin
        req_ready = 1'b1;
        mem_ad    = '0;
      end
      LS_ACCESS: begin
        if (word_st) begin
          mem_we = 1'b1;
          mem_d  = r.sd;
          done   = !r.need_bwb;
        end
      end
      LS_WAIT: ;
      LS_WRITE: begin
        mem_we = 1'b1;
        mem_d  = data;
        done   = !r.need_bwb;
      end
      LS_WB_DATA: begin
        wb_valid = 1'b1;
        wb_wa    = r.rd;
        wb_wd    = data;
        done     = !ld_bwb;
      end
      LS_WB_BASE: begin
        wb_valid = 1'b1;
        wb_wa    = r.rn;
        wb_wd    = r.oa;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldst_unit.sv
// Bench for ldst_unit: directed cases plus random LDR/STR traffic
// against a byte-array view of a 64-word big-endian memory.
module tb_ldst_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_byte;
  logic        req_pre;
  logic        req_up;
  logic        req_wb;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_sd;
  logic [3:0]  req_rd;
  logic [3:0]  req_rn;
  logic [31:0] mem_ad;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_q;
  logic        wb_valid;
  logic [3:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem [64];
  logic [31:0] ref_mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  typedef struct {
    bit        chk_ad;
    bit        we;
    bit [31:0] d;
    bit        wbv;
    bit [3:0]  wa;
    bit [31:0] wd;
    bit        dn;
  } cyc_t;

  ldst_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_byte   (req_byte),
    .req_pre    (req_pre),
    .req_up     (req_up),
    .req_wb     (req_wb),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_sd     (req_sd),
    .req_rd     (req_rd),
    .req_rn     (req_rn),
    .mem_ad     (mem_ad),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .mem_q      (mem_q),
    .wb_valid   (wb_valid),
    .wb_wa      (wb_wa),
    .wb_wd      (wb_wd),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_idx] <= pre_val;
    else if (mem_we) tb_mem[mem_ad[7:2]] <= mem_d;
    mem_q <= tb_mem[mem_ad[7:2]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] v);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = v;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input bit ld, input bit bt, input bit p,
                        input bit u, input bit w,
                        input logic [31:0] base,
                        input logic [31:0] off,
                        input logic [31:0] sd,
                        input logic [3:0] rd,
                        input logic [3:0] rn);
    cyc_t        q[$];
    cyc_t        c;
    logic [31:0] oa, ea, word, val, alad;
    logic [7:0]  b [4];
    logic [1:0]  k;
    logic [5:0]  idx;
    bit          nb;
    oa   = u ? base + off : base - off;
    ea   = p ? oa : base;
    nb   = !p || w;
    k    = ea[1:0];
    idx  = ea[7:2];
    alad = {ea[31:2], 2'b00};
    word = ref_mem[idx];
    for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
    c = '{default: 0};
    if (!ld && !bt) begin
      c.chk_ad = 1; c.we = 1; c.d = sd; c.dn = !nb;
      q.push_back(c);
      ref_mem[idx] = sd;
    end else begin
      c.chk_ad = 1;
      q.push_back(c);
      c = '{default: 0};
      q.push_back(c);
      if (ld) begin
        if (bt) val = {24'b0, b[k]};
        else val = {b[k], b[k+2'd1], b[k+2'd2], b[k+2'd3]};
        c.wbv = 1; c.wa = rd; c.wd = val;
        c.dn = !(nb && rn != rd);
      end else begin
        b[k] = sd[7:0];
        ref_mem[idx] = {b[0], b[1], b[2], b[3]};
        c.chk_ad = 1; c.we = 1; c.d = ref_mem[idx]; c.dn = !nb;
      end
      q.push_back(c);
    end
    if (nb && !(ld && rn == rd)) begin
      c = '{default: 0};
      c.wbv = 1; c.wa = rn; c.wd = oa; c.dn = 1;
      q.push_back(c);
    end
    chk("ready_before", {31'b0, req_ready}, 32'd1);
    req_load = ld; req_byte = bt; req_pre = p; req_up = u;
    req_wb = w; req_base = base; req_offset = off; req_sd = sd;
    req_rd = rd; req_rn = rn; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    foreach (q[i]) begin
      @(negedge clk);
      chk("ready_busy", {31'b0, req_ready}, 32'd0);
      chk("mem_we", {31'b0, mem_we}, {31'b0, q[i].we});
      if (q[i].chk_ad) chk("mem_ad", mem_ad, alad);
      if (q[i].we) chk("mem_d", mem_d, q[i].d);
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, q[i].wbv});
      if (q[i].wbv) begin
        chk("wb_wa", {28'b0, wb_wa}, {28'b0, q[i].wa});
        chk("wb_wd", wb_wd, q[i].wd);
      end
      chk("done", {31'b0, done}, {31'b0, q[i].dn});
    end
    @(negedge clk);
    chk("ready_after", {31'b0, req_ready}, 32'd1);
    chk("done_after", {31'b0, done}, 32'd0);
    chk("mem_word", tb_mem[idx], ref_mem[idx]);
  endtask

  initial begin
    clk = 0; reset = 1; req_valid = 0;
    req_load = 0; req_byte = 0; req_pre = 0; req_up = 0;
    req_wb = 0; req_base = 0; req_offset = 0; req_sd = 0;
    req_rd = 0; req_rn = 0;
    pre_we = 0; pre_idx = 0; pre_val = 0;
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_wbv", {31'b0, wb_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ad", mem_ad, 32'd0);
    chk("rst_d", mem_d, 32'd0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 64; i++) poke(i[5:0], $urandom);
    poke(6'h04, 32'hAABBCCDD);
    poke(6'h05, 32'h11223344);
    // test plan 1..5
    run_op(1, 0, 1, 1, 0, 32'h10, 32'h0, 32'h0, 4'd2, 4'd1);
    run_op(1, 1, 1, 1, 0, 32'h10, 32'h2, 32'h0, 4'd2, 4'd1);
    run_op(0, 1, 1, 1, 0, 32'h14, 32'h1, 32'h77, 4'd6, 4'd1);
    chk("strb_val", ref_mem[5], 32'h11773344);
    run_op(0, 0, 0, 0, 0, 32'h20, 32'h4, 32'hDEADBEEF, 4'd7, 4'd5);
    run_op(1, 0, 1, 1, 1, 32'h30, 32'h8, 32'h0, 4'd3, 4'd3);
    // rotated word and post-index load with base writeback
    run_op(1, 0, 1, 1, 0, 32'h11, 32'h0, 32'h0, 4'd1, 4'd2);
    run_op(1, 1, 0, 1, 0, 32'h13, 32'h4, 32'h0, 4'd1, 4'd2);
    run_op(0, 1, 1, 0, 1, 32'h18, 32'h1, 32'hA5, 4'd9, 4'd8);
    // reset during WAIT of a byte store
    poke(6'h09, 32'h55667788);
    req_load = 0; req_byte = 1; req_pre = 1; req_up = 1;
    req_wb = 0; req_base = 32'h24; req_offset = 32'h2;
    req_sd = 32'hEE; req_rd = 4'd1; req_rn = 4'd2;
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    chk("rstw_ready", {31'b0, req_ready}, 32'd1);
    chk("rstw_we", {31'b0, mem_we}, 32'd0);
    chk("rstw_wbv", {31'b0, wb_valid}, 32'd0);
    #2 reset = 0;
    repeat (3) @(negedge clk);
    chk("rstw_idle", {31'b0, req_ready}, 32'd1);
    chk("rstw_mem", tb_mem[9], 32'h55667788);
    // random traffic
    for (int n = 0; n < 60; n++) begin
      logic [3:0] rd, rn;
      logic [31:0] base;
      rd = 4'($urandom_range(0, 15));
      rn = ($urandom_range(0, 3) == 0) ? rd
                                       : 4'($urandom_range(0, 15));
      base = ($urandom_range(0, 3) == 0) ? $urandom
                                         : 32'($urandom_range(0, 255));
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), base,
             32'($urandom_range(0, 64)), $urandom, rd, rn);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
